// File: rtl/csi2rx_clk_pkg.sv
// Shared types and helpers for the CSI-2 RX clock frequency meter.
package csi2rx_clk_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PW_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        COMPARE = 2'd2
    } meter_state_t;

    // Increment v, holding at the all-ones value of a w-bit field (1 <= w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - w);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/csi2rx_edge_det.sv
// Edge detector for the synchronised measured clock: rise pulse, cycles-since-edge
// counter and last complete high/low phase widths.
module csi2rx_edge_det
    import csi2rx_clk_pkg::*;
#(
    parameter int PW_W = PW_W_DEF
) (
    input  logic            hclk,
    input  logic            ahb_hrst_n,
    input  logic            meas,
    output logic            rise,
    output logic [PW_W-1:0] stall_cnt,
    output logic [PW_W-1:0] high_width,
    output logic [PW_W-1:0] low_width
);

    logic            prev;
    logic            fall;
    logic            phase_ok;
    logic [PW_W-1:0] phase_cnt;

    assign rise = meas & ~prev;
    assign fall = ~meas & prev;

    always_ff @(posedge hclk) begin
        if (!ahb_hrst_n) begin
            prev       <= 1'b0;
            phase_ok   <= 1'b0;
            phase_cnt  <= '0;
            stall_cnt  <= '0;
            high_width <= '0;
            low_width  <= '0;
        end else begin
            prev <= meas;
            if (rise || fall) begin
                // The edge cycle is the first cycle of the new phase.
                phase_cnt <= PW_W'(1);
                stall_cnt <= '0;
                phase_ok  <= 1'b1;
                // Phase preceding the first edge after reset is partial, so drop it.
                if (phase_ok && fall) high_width <= phase_cnt;
                if (phase_ok && rise) low_width  <= phase_cnt;
            end else begin
                phase_cnt <= PW_W'(sat_inc(32'(phase_cnt), PW_W));
                stall_cnt <= PW_W'(sat_inc(32'(stall_cnt), PW_W));
            end
        end
    end

endmodule

// File: rtl/csi2rx_clk_freq_meter.sv
// Measures a synchronised clock against hclk: edge count over a programmable window,
// min/max bound check, stall detection and pulse-width reporting.
module csi2rx_clk_freq_meter
    import csi2rx_clk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PW_W  = PW_W_DEF
) (
    input  logic             hclk,
    input  logic             ahb_hrst_n,
    input  logic             meas_clk_sync,
    input  logic             start,
    input  logic             cont_mode,
    input  logic [CNT_W-1:0] window_cycles,
    input  logic [CNT_W-1:0] exp_min,
    input  logic [CNT_W-1:0] exp_max,
    input  logic [PW_W-1:0]  stall_limit,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] edge_count,
    output logic             freq_err,
    output logic             stall_err,
    output logic [PW_W-1:0]  high_width,
    output logic [PW_W-1:0]  low_width
);

    meter_state_t     state;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;
    logic [PW_W-1:0]  lim_q;
    logic             rise;
    logic [PW_W-1:0]  stall_cnt;

    csi2rx_edge_det #(.PW_W(PW_W)) u_edge_det (
        .hclk       (hclk),
        .ahb_hrst_n (ahb_hrst_n),
        .meas       (meas_clk_sync),
        .rise       (rise),
        .stall_cnt  (stall_cnt),
        .high_width (high_width),
        .low_width  (low_width)
    );

    always_ff @(posedge hclk) begin
        if (!ahb_hrst_n) begin
            state      <= IDLE;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            win_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            lim_q      <= '0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            edge_count <= '0;
            freq_err   <= 1'b0;
            stall_err  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state == MEASURE && lim_q != '0 && stall_cnt >= lim_q)
                stall_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start && window_cycles != '0) begin
                        win_q     <= window_cycles;
                        min_q     <= exp_min;
                        max_q     <= exp_max;
                        lim_q     <= stall_limit;
                        win_cnt   <= window_cycles;
                        edge_cnt  <= '0;
                        stall_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) edge_cnt <= CNT_W'(sat_inc(32'(edge_cnt), CNT_W));
                    win_cnt <= win_cnt - CNT_W'(1);
                    if (win_cnt == CNT_W'(1)) state <= COMPARE;
                end
                COMPARE: begin
                    edge_count <= edge_cnt;
                    freq_err   <= (edge_cnt < min_q) | (edge_cnt > max_q);
                    meas_valid <= 1'b1;
                    // Continuous mode re-arms with the latched window, no idle gap.
                    if (cont_mode) begin
                        win_cnt  <= win_q;
                        edge_cnt <= '0;
                        state    <= MEASURE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
